// File: rtl/eth_rx_fifo.sv
// Byte-wide show-ahead receive FIFO behind the Ethernet packet processor, with sticky overflow/underflow flags.
// Optional almost_full output is enabled by defining ETH_RX_FIFO_ALMOST_FULL_EN.
module eth_rx_fifo #(
  parameter int DEPTH = 8
`ifdef ETH_RX_FIFO_ALMOST_FULL_EN
  ,
  parameter int AF_LEVEL = DEPTH - 2
`endif
  ,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          w_enable,
  input  logic [7:0]    E_Data,
  output logic          FULL,
  input  logic          r_enable,
  output logic [7:0]    r_data,
  output logic          EMPTY,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err
`ifdef ETH_RX_FIFO_ALMOST_FULL_EN
  ,
  output logic          almost_full
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);
  localparam logic [AW:0] ZERO_CNT = (AW + 1)'(0);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;
  logic          r_unf;

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [AW:0]   w_count_nxt;
  logic          w_ovf_nxt;
  logic          w_unf_nxt;

  // Acceptance uses the registered flags, so a full FIFO rejects a write even when a pop happens alongside it.
  assign w_wr_acc = w_enable & ~r_full;
  assign w_rd_acc = r_enable & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + ONE_CNT;
      2'b01:   w_count_nxt = r_count - ONE_CNT;
      default: w_count_nxt = r_count;
    endcase
  end

  // A fresh error wins over a simultaneous clear.
  always_comb begin
    w_ovf_nxt = r_ovf;
    if (w_enable && r_full) begin
      w_ovf_nxt = 1'b1;
    end else if (clr_err) begin
      w_ovf_nxt = 1'b0;
    end else begin
      w_ovf_nxt = r_ovf;
    end
  end

  always_comb begin
    w_unf_nxt = r_unf;
    if (r_enable && r_empty) begin
      w_unf_nxt = 1'b1;
    end else if (clr_err) begin
      w_unf_nxt = 1'b0;
    end else begin
      w_unf_nxt = r_unf;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= ZERO_CNT;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == ZERO_CNT);
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (!n_rst && w_wr_acc) begin
      r_mem[r_wptr] <= E_Data;
    end
  end

  assign r_data    = r_mem[r_rptr];
  assign FULL      = r_full;
  assign EMPTY     = r_empty;
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

`ifdef ETH_RX_FIFO_ALMOST_FULL_EN
  localparam logic [AW:0] AF_CNT = (AW + 1)'(AF_LEVEL);
  logic r_af;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_af <= 1'b0;
    end else begin
      r_af <= (w_count_nxt >= AF_CNT);
    end
  end

  assign almost_full = r_af;
`endif

endmodule

// File: tb/tb_eth_rx_fifo.sv
// Self-checking bench for eth_rx_fifo: directed scenarios followed by random traffic,
// compared against a queue-based model of the FIFO's externally visible behaviour.
module tb_eth_rx_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          n_rst;
  logic          w_enable;
  logic [7:0]    E_Data;
  logic          FULL;
  logic          r_enable;
  logic [7:0]    r_data;
  logic          EMPTY;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic          clr_err;

  int n_checks;
  int n_errors;

  logic [7:0] m_q[$];
  logic       m_ovf;
  logic       m_unf;

  eth_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .w_enable  (w_enable),
    .E_Data    (E_Data),
    .FULL      (FULL),
    .r_enable  (r_enable),
    .r_data    (r_data),
    .EMPTY     (EMPTY),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all visible outputs with the model.
  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_q.size()));
    chk({tag, ".FULL"},  32'(FULL),  32'(m_q.size() == DEPTH));
    chk({tag, ".EMPTY"}, 32'(EMPTY), 32'(m_q.size() == 0));
    chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    chk({tag, ".unf"},   32'(underflow), 32'(m_unf));
    if (m_q.size() != 0) begin
      chk({tag, ".rdata"}, 32'(r_data), 32'(m_q[0]));
    end
  endtask

  // Drive one cycle, advance the model by the FIFO rules, then check #1 after the edge.
  task automatic step(input string tag, input logic rst, input logic we, input logic [7:0] d,
                      input logic re, input logic clr);
    bit full_pre, empty_pre;
    n_rst    = rst;
    w_enable = we;
    E_Data   = d;
    r_enable = re;
    clr_err  = clr;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      full_pre  = (m_q.size() == DEPTH);
      empty_pre = (m_q.size() == 0);
      if (re && !empty_pre) void'(m_q.pop_front());
      if (we && !full_pre) m_q.push_back(d);
      m_ovf = (we && full_pre) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = (re && empty_pre) ? 1'b1 : (clr ? 1'b0 : m_unf);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    n_rst = 1'b1; w_enable = 1'b0; E_Data = 8'h00; r_enable = 1'b0; clr_err = 1'b0;
    #2;

    step("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_empty", 32'(EMPTY), 32'd1);
    chk("reset_count", 32'(count), 32'd0);

    step("wr_a5", 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_visible", 32'(r_data), 32'hA5);
    step("pop_a5", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("a5_drained", 32'(EMPTY), 32'd1);

    for (int i = 0; i < 8; i++) step("fill", 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(FULL), 32'd1);
    step("wr_ff_full", 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", 32'(r_data), 32'(i));
      step("drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end

    step("clr0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step("fill2", 1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step("rw_full", 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    chk("rw_full_count", 32'(count), 32'd7);
    chk("rw_full_ovf", 32'(overflow), 32'd1);
    step("clr_ovf", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    step("rst2", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("pre3", 1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step("wrap", 1'b0, 1'b1, 8'(8'h43 + i), 1'b1, 1'b0);
      chk("wrap_count", 32'(count), 32'd3);
    end

    step("rst3", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("rw_empty", 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_rdata", 32'(r_data), 32'h3C);
    step("clr_unf_and_err", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step("burst", 1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step("rst_burst", 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    chk("rst_burst_count", 32'(count), 32'd0);
    chk("rst_burst_flags", 32'({overflow, underflow}), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 200) % 3 == 0) ? 80 : (((i / 200) % 3 == 1) ? 20 : 50);
      step("rand",
           ($urandom_range(0, 499) == 0),
           ($urandom_range(0, 99) < wp),
           8'($urandom),
           ($urandom_range(0, 99) < (100 - wp)),
           ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
